// File: rtl/pong_hex_pkg.sv
// Shared codes, display states and banner text for the Pong HEX0-HEX5 display sequencer.
package pong_hex_pkg;

  localparam logic [3:0] LT_P     = 4'd0;
  localparam logic [3:0] LT_A     = 4'd1;
  localparam logic [3:0] LT_D     = 4'd2;
  localparam logic [3:0] LT_L     = 4'd3;
  localparam logic [3:0] LT_E     = 4'd4;
  localparam logic [3:0] LT_U     = 4'd5;
  localparam logic [3:0] LT_R     = 4'd6;
  localparam logic [3:0] LT_B     = 4'd7;
  localparam logic [3:0] LT_SPACE = 4'd8;
  localparam logic [3:0] LT_V     = 4'd9;

  localparam logic [3:0] NUM_BLANK = 4'hF;

  localparam int unsigned BANNER_LEN = 12;

  typedef enum logic [1:0] {BANNER, PLAY, LVL, OVER} disp_state_e;

  // c[0] sits in the top nibble
  localparam logic [47:0] BANNER_STR = {LT_P, LT_A, LT_D, LT_D, LT_L, LT_E,
                                        LT_SPACE, LT_SPACE, LT_SPACE,
                                        LT_SPACE, LT_SPACE, LT_SPACE};

  function automatic logic [3:0] banner_char(input logic [3:0] idx);
    int unsigned base;
    base = 47 - 4 * int'(idx);
    return BANNER_STR[base -: 4];
  endfunction

  function automatic logic [3:0] num_or_blank(input logic [3:0] v);
    return (v > 4'd9) ? NUM_BLANK : v;
  endfunction

endpackage

// File: rtl/hex_display_sequencer_if.sv
// Game-event inputs and per-digit display outputs of the HEX display sequencer.
interface hex_display_sequencer_if;
  logic        game_start;
  logic        level_up;
  logic        game_over;
  logic [9:0]  score;
  logic [3:0]  level;
  logic [23:0] digit_code;
  logic [5:0]  digit_is_num;

  modport master (output game_start, level_up, game_over, score, level,
                  input  digit_code, digit_is_num);
  modport slave  (input  game_start, level_up, game_over, score, level,
                  output digit_code, digit_is_num);
endinterface

// File: rtl/hex_display_sequencer_bin2bcd.sv
// Iterative double-dabble: 10-bit binary to 3 BCD digits in 10 cycles after start.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [9:0]  bin,
  output logic [11:0] bcd,
  output logic        done
);

  logic [21:0] work;
  logic [3:0]  iter;
  logic        busy;

  function automatic logic [21:0] dd_step(input logic [21:0] w);
    logic [21:0] t;
    t = w;
    for (int unsigned n = 0; n < 3; n++) begin
      if (t[10 + 4 * n +: 4] >= 4'd5)
        t[10 + 4 * n +: 4] = t[10 + 4 * n +: 4] + 4'd3;
    end
    return {t[20:0], 1'b0};
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      work <= '0;
      iter <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      work <= {12'd0, bin};
      iter <= '0;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      work <= dd_step(work);
      iter <= iter + 4'd1;
      if (iter == 4'd9) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  // Valid only while done is high; the caller keeps its own copy.
  assign bcd = work[21:10];

endmodule

// File: rtl/hex_display_sequencer.sv
// Pong HEX0-HEX5 display sequencer: banner scroll, play/score view, LEVEL message, blinking DEAD.
module hex_display_sequencer
  import pong_hex_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 25_000_000,
  parameter int unsigned HOLD_TICKS = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  hex_display_sequencer_if.slave  bus
);

  localparam int unsigned TW = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
  localparam int unsigned HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  disp_state_e state;
  logic [TW-1:0] tcnt;
  logic [3:0]    offset;
  logic [HW-1:0] hold;
  logic          phase;
  logic [9:0]    score_lat;
  logic [11:0]   bcd_hold;
  logic [23:0]   code_r;
  logic [5:0]    num_r;

  logic          tick;
  logic          start_conv;
  logic          conv_done;
  logic          ev_over, ev_lvl, ev_start;
  logic [9:0]    score_clamped;
  logic [11:0]   conv_bcd;
  logic [11:0]   bcd_view;
  logic [11:0]   score_code;
  logic [3:0]    lvl_num;
  logic [23:0]   code_n;
  logic [5:0]    num_n;

  assign tick          = (tcnt == TW'(TICK_DIV - 1));
  assign score_clamped = (bus.score > 10'd999) ? 10'd999 : bus.score;
  assign start_conv    = (bus.score != score_lat);

  bin2bcd_seq u_bcd (
    .clk    (clk),
    .resetn (resetn),
    .start  (start_conv),
    .bin    (score_clamped),
    .bcd    (conv_bcd),
    .done   (conv_done)
  );

  // Bypass on done so the fresh result reaches the output register without an extra cycle.
  assign bcd_view = conv_done ? conv_bcd : bcd_hold;
  assign lvl_num  = num_or_blank(bus.level);

  assign ev_over  = bus.game_over;
  assign ev_lvl   = bus.level_up   && (state == PLAY   || state == LVL);
  assign ev_start = bus.game_start && (state == BANNER || state == OVER);

  function automatic logic [23:0] banner_view(input logic [3:0] off);
    logic [23:0] r;
    logic [4:0]  sum;
    r = '0;
    for (int unsigned j = 0; j < 6; j++) begin
      sum = {1'b0, off} + 5'(j);
      if (sum >= 5'(BANNER_LEN))
        sum = sum - 5'(BANNER_LEN);
      r[4 * (5 - j) +: 4] = banner_char(sum[3:0]);
    end
    return r;
  endfunction

  always_comb begin
    score_code[11:8] = (bcd_view[11:8] == 4'd0) ? NUM_BLANK : bcd_view[11:8];
    score_code[7:4]  = (bcd_view[11:4] == 8'd0) ? NUM_BLANK : bcd_view[7:4];
    score_code[3:0]  = bcd_view[3:0];
  end

  always_comb begin
    code_n = {6{LT_SPACE}};
    num_n  = '0;
    case (state)
      BANNER: code_n = banner_view(offset);
      PLAY: begin
        code_n = {LT_L, lvl_num, LT_SPACE, score_code};
        num_n  = 6'b010111;
      end
      LVL: begin
        code_n = {LT_L, LT_E, LT_V, LT_E, LT_L, lvl_num};
        num_n  = 6'b000001;
      end
      OVER: begin
        if (phase) begin
          code_n = {LT_L, lvl_num, LT_SPACE, score_code};
          num_n  = 6'b010111;
        end else begin
          code_n = {LT_SPACE, LT_SPACE, LT_D, LT_E, LT_A, LT_D};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= BANNER;
      tcnt      <= '0;
      offset    <= '0;
      hold      <= '0;
      phase     <= 1'b0;
      score_lat <= '0;
      bcd_hold  <= '0;
      code_r    <= {6{LT_SPACE}};
      num_r     <= '0;
    end else begin
      code_r    <= code_n;
      num_r     <= num_n;
      score_lat <= bus.score;
      if (conv_done)
        bcd_hold <= conv_bcd;

      if (ev_over) begin
        state <= OVER;
        tcnt  <= '0;
        phase <= 1'b0;
      end else if (ev_lvl) begin
        state <= LVL;
        tcnt  <= '0;
        hold  <= '0;
      end else if (ev_start) begin
        state <= PLAY;
        tcnt  <= '0;
      end else begin
        tcnt <= tick ? '0 : tcnt + TW'(1);
        if (tick) begin
          case (state)
            BANNER: offset <= (offset == 4'd11) ? 4'd0 : offset + 4'd1;
            LVL: begin
              if (hold == HW'(HOLD_TICKS - 1))
                state <= PLAY;
              else
                hold <= hold + HW'(1);
            end
            OVER:    phase <= ~phase;
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.digit_code   = code_r;
  assign bus.digit_is_num = num_r;

endmodule

// File: tb/tb_hex_display_sequencer.sv
// Scoreboard bench for hex_display_sequencer: per-cycle reference view vs registered DUT outputs.
module tb_hex_display_sequencer;

  localparam int unsigned TD = 4;
  localparam int unsigned HT = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  hex_display_sequencer_if bus ();

  hex_display_sequencer #(.TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] code;
    logic [5:0]  num;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // reference model: mode 0=banner 1=play 2=level msg 3=over; age = edges since entry
  int m_mode, m_age, m_prev, m_run, m_shown;
  logic [9:0] cur_sc;
  logic [3:0] cur_lv;

  function automatic logic [3:0] ch(input byte c);
    case (c)
      "P": return 4'd0;
      "A": return 4'd1;
      "D": return 4'd2;
      "L": return 4'd3;
      "E": return 4'd4;
      "U": return 4'd5;
      "R": return 4'd6;
      "B": return 4'd7;
      "V": return 4'd9;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [23:0] text_code(input string s);
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r[23 - 4 * i -: 4] = ch(s[i]);
    return r;
  endfunction

  function automatic logic [3:0] nb(input int v);
    return (v > 9) ? 4'hF : 4'(v);
  endfunction

  function automatic exp_t view(input int mode, input int age, input int lvl, input int shown);
    exp_t e;
    string ban;
    int ticks, sv, h, t, o;
    ban   = "PADDLE      ";
    ticks = age / TD;
    sv    = (shown > 999) ? 999 : shown;
    h = sv / 100;
    t = (sv / 10) % 10;
    o = sv % 10;
    e.code = '0;
    e.num  = '0;
    if (mode == 0) begin
      for (int j = 0; j < 6; j++) e.code[23 - 4 * j -: 4] = ch(ban[(ticks + j) % 12]);
    end else if (mode == 2) begin
      e.code = {text_code("LEVEL ")} & 24'hFFFFF0 | {20'd0, nb(lvl)};
      e.num  = 6'b000001;
    end else if (mode == 3 && (ticks % 2) == 0) begin
      e.code = text_code("  DEAD");
    end else begin
      e.code = {ch("L"), nb(lvl), ch(" "), (h == 0) ? 4'hF : 4'(h),
                (h == 0 && t == 0) ? 4'hF : 4'(t), 4'(o)};
      e.num  = 6'b010111;
    end
    return e;
  endfunction

  task automatic model_step();
    exp_t e;
    int sc;
    if (!resetn) begin
      e.code = 24'h888888;
      e.num  = 6'h00;
      q.push_back(e);
      m_mode = 0; m_age = 0; m_prev = 0; m_run = 11; m_shown = 0;
      return;
    end
    q.push_back(view(m_mode, m_age, int'(bus.level), m_shown));
    if (bus.game_over) begin
      m_mode = 3; m_age = 0;
    end else if (bus.level_up && (m_mode == 1 || m_mode == 2)) begin
      m_mode = 2; m_age = 0;
    end else if (bus.game_start && (m_mode == 0 || m_mode == 3)) begin
      m_mode = 1; m_age = 0;
    end else begin
      m_age++;
      if (m_mode == 2 && m_age == TD * HT) begin
        m_mode = 1; m_age = 0;
      end
    end
    // a score is shown once it has been held for 11 consecutive edges
    sc = int'(bus.score);
    if (sc == m_prev) begin
      if (m_run < 11) m_run++;
    end else begin
      m_prev = sc; m_run = 1;
    end
    if (m_run >= 11) m_shown = m_prev;
  endtask

  task automatic cyc(input logic rst, input logic gs, input logic lu, input logic go);
    @(negedge clk);
    resetn          = rst;
    bus.game_start  = gs;
    bus.level_up    = lu;
    bus.game_over   = go;
    bus.score       = cur_sc;
    bus.level       = cur_lv;
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_mid(input int hold_cycles);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (bus.digit_code !== 24'h888888 || bus.digit_is_num !== 6'h00) begin
      errors++;
      $display("FAIL async_reset code=%h exp=888888 is_num=%h exp=00",
               bus.digit_code, bus.digit_is_num);
    end
    repeat (hold_cycles) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (bus.digit_code !== e.code || bus.digit_is_num !== e.num) begin
          errors++;
          $display("FAIL view t=%0t code=%h exp=%h is_num=%h exp=%h",
                   $time, bus.digit_code, e.code, bus.digit_is_num, e.num);
        end
      end
    end
  end

  initial begin : stimulus
    int r;
    bus.game_start = 1'b0;
    bus.level_up   = 1'b0;
    bus.game_over  = 1'b0;
    bus.score      = '0;
    bus.level      = '0;
    cur_sc = '0;
    cur_lv = '0;
    m_mode = 0; m_age = 0; m_prev = 0; m_run = 11; m_shown = 0;

    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    idle(12 * TD + 3);

    cur_lv = 4'd3;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    idle(4);
    cur_sc = 10'd47;   idle(15);
    cur_sc = 10'd1023; idle(15);

    cur_lv = 4'd4;
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    idle(2 * TD * HT + 3);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    idle(5);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    idle(2 * TD * HT + 3);

    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    idle(6 * TD);

    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cur_sc = 10'd500; idle(5);
    cur_sc = 10'd321; idle(14);
    cur_sc = 10'd5;   idle(14);

    reset_mid(2);
    idle(6);
    reset_mid(2);
    idle(2 * TD + 1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cur_sc = 10'd888; idle(4);
    reset_mid(3);
    idle(14);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    idle(4);

    for (int i = 0; i < 2000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 30)       cur_sc = 10'($urandom_range(0, 1023));
      else if (r < 36)  cur_sc = 10'($urandom_range(990, 1023));
      if ($urandom_range(0, 99) < 2) cur_lv = 4'($urandom_range(0, 11));
      if (r == 999) begin
        reset_mid(int'($urandom_range(1, 3)));
      end else begin
        cyc(1'b1,
            $urandom_range(0, 39) == 0,
            $urandom_range(0, 29) == 0,
            $urandom_range(0, 79) == 0);
      end
    end
    idle(3);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
